// File: rtl/carry_select_adder_pkg.sv
// Purpose: shared sizing constants and helpers for the carry-select adder.
// Latency: n/a (package only).
// Backpressure: n/a.
package carry_select_adder_pkg;

  localparam int CSA_DEFAULT_WIDTH = 4;
  localparam int CSA_DEFAULT_BLOCK = 2;

  // Number of carry-select blocks the operand range is cut into.
  function automatic int csa_num_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// Purpose: BLOCK-bit ripple-carry adder, the leaf of the carry-select adder.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module csa_rca_block
  import carry_select_adder_pkg::*;
#(
  parameter int BLOCK = CSA_DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] c;

  // Ripple the carry from bit 0 upwards through the block.
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[BLOCK];
  end

endmodule

// File: rtl/carry_select_adder.sv
// Purpose: registered WIDTH-bit carry-select adder, {Cout,S} = A + B + Cin.
// Latency: 1 cycle (2 with CARRY_SELECT_ADDER_INPUT_REG_EN defined); one add per cycle.
// Backpressure: none; every rising clk edge samples new operands.
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = CSA_DEFAULT_WIDTH,
  parameter int BLOCK = CSA_DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NB = csa_num_blocks(WIDTH, BLOCK);

  if ((BLOCK < 1) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
    $fatal(1, "carry_select_adder: WIDTH must be a nonzero multiple of BLOCK");
  end

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             cin_c;

`ifdef CARRY_SELECT_ADDER_INPUT_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  // Capture operands so the adder core sees a full cycle of settled inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= Cin;
    end
  end

  assign a_c   = a_q;
  assign b_c   = b_q;
  assign cin_c = cin_q;
`else
  assign a_c   = A;
  assign b_c   = B;
  assign cin_c = Cin;
`endif

  // Per-block candidate results: lo assumes carry-in 0, hi assumes carry-in 1.
  logic [BLOCK-1:0] sum_lo  [NB];
  logic [BLOCK-1:0] sum_hi  [NB];
  logic             cout_lo [NB];
  logic             cout_hi [NB];

  for (genvar k = 0; k < NB; k++) begin : g_blk
    if (k == 0) begin : g_first
      // Block 0 consumes Cin directly; hi aliases lo since the select
      // chain never picks it (its "carry-in select" is tied low below).
      csa_rca_block #(.BLOCK(BLOCK)) u_rca (
        .a    (a_c[BLOCK-1:0]),
        .b    (b_c[BLOCK-1:0]),
        .cin  (cin_c),
        .sum  (sum_lo[0]),
        .cout (cout_lo[0])
      );
      assign sum_hi[0]  = sum_lo[0];
      assign cout_hi[0] = cout_lo[0];
    end else begin : g_upper
      csa_rca_block #(.BLOCK(BLOCK)) u_rca0 (
        .a    (a_c[k*BLOCK +: BLOCK]),
        .b    (b_c[k*BLOCK +: BLOCK]),
        .cin  (1'b0),
        .sum  (sum_lo[k]),
        .cout (cout_lo[k])
      );
      csa_rca_block #(.BLOCK(BLOCK)) u_rca1 (
        .a    (a_c[k*BLOCK +: BLOCK]),
        .b    (b_c[k*BLOCK +: BLOCK]),
        .cin  (1'b1),
        .sum  (sum_hi[k]),
        .cout (cout_hi[k])
      );
    end
  end

  logic [WIDTH-1:0] sum_c;
  logic             chain;

  // Mux chain: the carry out of each block picks the next block's precomputed result.
  always_comb begin
    sum_c = '0;
    chain = 1'b0;
    for (int k = 0; k < NB; k++) begin
      sum_c[k*BLOCK +: BLOCK] = chain ? sum_hi[k] : sum_lo[k];
      chain                   = chain ? cout_hi[k] : cout_lo[k];
    end
  end

  // Output register; reset clears it immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum_c;
      Cout <= chain;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// Purpose: self-checking bench for carry_select_adder (4/2, 8/4 and 8/2 builds).
// Latency: tracks 1 cycle, or 2 with CARRY_SELECT_ADDER_INPUT_REG_EN defined.
// Backpressure: n/a.
module tb_carry_select_adder;

`ifdef CARRY_SELECT_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] s4;
  logic       cout4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] s8a, s8b;
  logic       c8a, c8b;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: expected {Cout,S} results in flight, oldest at index LAT-1.
  logic [4:0] p4 [LAT];
  logic [8:0] p8 [LAT];

  carry_select_adder #(.WIDTH(4), .BLOCK(2)) dut (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .S(s4), .Cout(cout4)
  );
  carry_select_adder #(.WIDTH(8), .BLOCK(4)) dut84 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .S(s8a), .Cout(c8a)
  );
  carry_select_adder #(.WIDTH(8), .BLOCK(2)) dut82 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .S(s8b), .Cout(c8b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < LAT; i++) begin
      p4[i] = '0;
      p8[i] = '0;
    end
  endtask

  // Advance one clock; the model shifts in the sum of the operands presented at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        p4[i] = p4[i-1];
        p8[i] = p8[i-1];
      end
      p4[0] = a4 + b4 + cin4;
      p8[0] = a8 + b8 + cin8;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a4 = 4'd9; b4 = 4'd6; cin4 = 1'b1;
    #1;
    n_chk++;
    if ({cout4, s4} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%0d exp=0", {cout4, s4});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({cout4, s4} !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%0d exp=0", i, {cout4, s4});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      n_chk++;
      if ({cout4, s4} !== p4[LAT-1]) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d got=%0d exp=%0d", i, {cout4, s4}, p4[LAT-1]);
      end
    end
    n_chk++;
    if ({cout4, s4} !== 5'd16) begin
      n_fail++;
      $display("FAIL reset_first_result got=%0d exp=16", {cout4, s4});
    end
  endtask

  task automatic test_exhaustive(input logic cin);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a); b4 = 4'(b); cin4 = cin;
        tick();
        n_chk++;
        if ({cout4, s4} !== p4[LAT-1]) begin
          n_fail++;
          $display("FAIL exhaustive cin=%0b a=%0d b=%0d got=%0d exp=%0d",
                   cin, a, b, {cout4, s4}, p4[LAT-1]);
        end
      end
    end
  endtask

  task automatic test_corners();
    logic [3:0] ca [4];
    logic [3:0] cb [4];
    logic       cc [4];
    logic [4:0] ce [4];
    ca[0] = 4'd0;  cb[0] = 4'd0;  cc[0] = 1'b1; ce[0] = 5'd1;
    ca[1] = 4'd15; cb[1] = 4'd15; cc[1] = 1'b1; ce[1] = 5'd31;
    ca[2] = 4'd15; cb[2] = 4'd0;  cc[2] = 1'b1; ce[2] = 5'd16;
    ca[3] = 4'd8;  cb[3] = 4'd8;  cc[3] = 1'b0; ce[3] = 5'd16;
    for (int i = 0; i < 4; i++) begin
      a4 = ca[i]; b4 = cb[i]; cin4 = cc[i];
      for (int j = 0; j < LAT; j++) tick();
      n_chk++;
      if ({cout4, s4} !== ce[i]) begin
        n_fail++;
        $display("FAIL corner%0d a=%0d b=%0d cin=%0b got=%0d exp=%0d",
                 i, ca[i], cb[i], cc[i], {cout4, s4}, ce[i]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 24; i++) begin
      a4 = 4'($urandom_range(1, 15)); b4 = 4'($urandom); cin4 = 1'($urandom);
      if (i == 12) begin
        // Pulse reset between edges; in-flight results must vanish at once.
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cout4, s4} !== 5'd0) begin
          n_fail++;
          $display("FAIL midreset_async got=%0d exp=0", {cout4, s4});
        end
        clear_model();
        #1;
        rst_n = 1'b1;
      end
      tick();
      n_chk++;
      if ({cout4, s4} !== p4[LAT-1]) begin
        n_fail++;
        $display("FAIL midstream cyc=%0d got=%0d exp=%0d", i, {cout4, s4}, p4[LAT-1]);
      end
    end
  endtask

  task automatic test_param_sweep();
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      tick();
      n_chk++;
      if ({c8a, s8a} !== p8[LAT-1]) begin
        n_fail++;
        $display("FAIL sweep_w8b4 cyc=%0d got=%0d exp=%0d", i, {c8a, s8a}, p8[LAT-1]);
      end
      n_chk++;
      if ({c8b, s8b} !== p8[LAT-1]) begin
        n_fail++;
        $display("FAIL sweep_w8b2 cyc=%0d got=%0d exp=%0d", i, {c8b, s8b}, p8[LAT-1]);
      end
      n_chk++;
      if ({cout4, s4} !== p4[LAT-1]) begin
        n_fail++;
        $display("FAIL sweep_w4b2 cyc=%0d got=%0d exp=%0d", i, {cout4, s4}, p4[LAT-1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    clear_model();
    test_reset();
    test_exhaustive(1'b1);
    test_corners();
    test_exhaustive(1'b0);
    test_back_to_back_reset();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
